// File: rtl/pwm_pkg.sv
// Shared constants and count-direction type for the multi-channel PWM.
// The direction enum is only used when PWM_MULTI_CENTER_EN is defined.
package pwm_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 4;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow/active pair and registered compare output.
// The active duty only changes on the shared wrap strobe.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             wrap,
    input  logic [WIDTH-1:0] duty,
    input  logic [WIDTH-1:0] cnt,
    output logic             out
);

    logic [WIDTH-1:0] duty_sh;
    logic [WIDTH-1:0] duty_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_sh  <= '0;
            duty_act <= '0;
            out      <= 1'b0;
        end else begin
            if (load)
                duty_sh <= duty;
            // a load landing on the wrap clock bypasses the shadow
            if (wrap)
                duty_act <= load ? duty : duty_sh;
            out <= (duty_act > cnt);
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared counter and glitch-free shadowed updates.
// Define PWM_MULTI_CENTER_EN for centre-aligned (up/down) counting.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          period,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      load,
    output logic [CHANNELS-1:0]       out,
    output logic                      sync,
    output logic                      pend
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] per_act;
    logic [WIDTH-1:0] per_sh;
    logic             wrap;

`ifdef PWM_MULTI_CENTER_EN
    dir_t dir;
    dir_t dir_nxt;

    // wrap marks the last clock before the cnt=0 that starts counting up
    always_comb begin
        wrap    = 1'b0;
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (dir == UP) begin
            if (cnt == per_act) begin
                if (per_act <= WIDTH'(1)) begin
                    wrap    = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    dir_nxt = DOWN;
                    cnt_nxt = cnt - WIDTH'(1);
                end
            end else begin
                cnt_nxt = cnt + WIDTH'(1);
            end
        end else begin
            if (cnt == WIDTH'(1)) begin
                wrap    = 1'b1;
                cnt_nxt = '0;
                dir_nxt = UP;
            end else begin
                cnt_nxt = cnt - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dir <= UP;
        else
            dir <= dir_nxt;
    end
`else
    always_comb begin
        wrap    = (cnt == per_act);
        cnt_nxt = wrap ? '0 : cnt + WIDTH'(1);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            per_act <= '1;
            per_sh  <= '1;
            pend    <= 1'b0;
            sync    <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (load)
                per_sh <= period;
            if (wrap)
                per_act <= load ? period : per_sh;
            pend <= wrap ? 1'b0 : (pend | load);
            sync <= (cnt == '0);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .load (load),
            .wrap (wrap),
            .duty (duty[i*WIDTH +: WIDTH]),
            .cnt  (cnt),
            .out  (out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus random loads
// against a cycle-position reference model.
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [7:0]  period = '0;
    logic [31:0] duty = '0;
    logic [3:0]  out;
    logic        sync;
    logic        pend;

    int vecs = 0;
    int errs = 0;

    // reference model: position within cycle, active and shadow settings
    int       m_ph;
    int       m_P;
    int       m_D[4];
    int       m_shP;
    int       m_shD[4];
    logic     m_pend;
    logic [3:0] exp_out;
    logic     exp_sync;

    int hi[4];
    int ns;

    always #5 clk = ~clk;

    pwm_multi #(
        .WIDTH(8),
        .CHANNELS(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .period (period),
        .duty   (duty),
        .load   (load),
        .out    (out),
        .sync   (sync),
        .pend   (pend)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clen(int p);
`ifdef PWM_MULTI_CENTER_EN
        return (p == 0) ? 1 : 2 * p;
`else
        return p + 1;
`endif
    endfunction

    function automatic int cval(int ph, int p);
`ifdef PWM_MULTI_CENTER_EN
        return (ph <= p) ? ph : 2 * p - ph;
`else
        return ph;
`endif
    endfunction

    task automatic model_reset();
        m_ph = 0;
        m_P = 255;
        m_shP = 255;
        m_pend = 1'b0;
        exp_out = '0;
        exp_sync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_D[i] = 0;
            m_shD[i] = 0;
        end
    endtask

    task automatic model_step();
        int c;
        c = cval(m_ph, m_P);
        for (int i = 0; i < 4; i++)
            exp_out[i] = (m_D[i] > c);
        exp_sync = (c == 0);
        if (m_ph == clen(m_P) - 1) begin
            m_P = load ? int'(period) : m_shP;
            for (int i = 0; i < 4; i++)
                m_D[i] = load ? int'(duty[i*8 +: 8]) : m_shD[i];
            m_pend = 1'b0;
            m_ph = 0;
        end else begin
            m_ph++;
            if (load)
                m_pend = 1'b1;
        end
        if (load) begin
            m_shP = period;
            for (int i = 0; i < 4; i++)
                m_shD[i] = duty[i*8 +: 8];
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        load = 1'b0;
        chk("out", out, exp_out);
        chk("sync", sync, exp_sync);
        chk("pend", pend, m_pend);
    endtask

    task automatic do_load(logic [7:0] p, logic [31:0] d);
        period = p;
        duty = d;
        load = 1'b1;
    endtask

    task automatic wait_sync();
        bit ok;
        ok = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (sync) begin
                ok = 1;
                break;
            end
        end
        chk("sync_wait", ok, 1);
    endtask

    task automatic measure(int n, int lk, logic [7:0] lp, logic [31:0] ld);
        for (int i = 0; i < 4; i++)
            hi[i] = 0;
        ns = 0;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 4; i++)
                if (out[i]) hi[i]++;
            if (sync) ns++;
            if (k == n - 1) break;
            if (k == lk) do_load(lp, ld);
            tick();
        end
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out, 0);
        chk("rst_sync", sync, 0);
        chk("rst_pend", pend, 0);
        rst = 1'b0;
        tick();
        tick();

`ifdef PWM_MULTI_CENTER_EN
        do_load(8'd4, 32'h0202_0202);
        tick();
        wait_sync();
        measure(8, -1, 8'd0, 32'd0);
        chk("ctr_hi", hi[0], 3);
        chk("ctr_nsync", ns, 1);
        tick();
        chk("ctr_sync_next", sync, 1);
`else
        // P=9 with D={0,3,9,200}
        do_load(8'd9, {8'd200, 8'd9, 8'd3, 8'd0});
        tick();
        wait_sync();
        measure(10, -1, 8'd0, 32'd0);
        chk("hi_ch0", hi[0], 0);
        chk("hi_ch1", hi[1], 3);
        chk("hi_ch2", hi[2], 9);
        chk("hi_ch3", hi[3], 10);
        chk("nsync10", ns, 1);
        tick();
        chk("sync_period10", sync, 1);

        // mid-cycle duty change: 2 this cycle, 5 the next
        do_load(8'd9, 32'd2);
        tick();
        wait_sync();
        measure(10, 3, 8'd9, 32'd5);
        chk("mid_hi_old", hi[0], 2);
        tick();
        measure(10, -1, 8'd0, 32'd0);
        chk("mid_hi_new", hi[0], 5);
        chk("mid_nsync", ns, 1);

        // load on the exact wrap clock
        for (int k = 0; k < 600; k++) begin
            if (m_ph == clen(m_P) - 1) break;
            tick();
        end
        chk("wrap_found", m_ph, clen(m_P) - 1);
        do_load(8'd4, 32'd3);
        tick();
        chk("wrap_pend", pend, 0);
        wait_sync();
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n++;
            if (sync) break;
        end
        chk("wrap_sync_gap", n, 5);

        // P=0 boundary
        do_load(8'd0, {8'd0, 8'd1, 8'd0, 8'd1});
        tick();
        wait_sync();
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("p0_out", out, 4'b0101);
            chk("p0_sync", sync, 1);
        end
`endif

        // random loads against the model
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 9) == 0)
                do_load(8'($urandom_range(0, 12)),
                        {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                         8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))});
            tick();
        end

        // async reset mid-cycle with a pending load
        do_load(8'd9, 32'h0404_0404);
        tick();
        wait_sync();
        tick();
        tick();
        do_load(8'd6, 32'h0101_0101);
        tick();
        chk("pre_rst_pend", pend, 1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_out", out, 0);
        chk("arst_sync", sync, 0);
        chk("arst_pend", pend, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("restart_sync", sync, 1);
        for (int k = 0; k < 40; k++)
            tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
